cu_bj: RTL

- Multi-cycle control unit for the RV32 subset CPU, extended with BEQ, BNE, JAL and JALR.
- Sequences PC, IR, register heap, ALU/FR, data RAM and MDR through one Moore FSM.
- Takes decoder flags from the ID stage and FR from the ALU register. Drives every write-enable and mux select.
- Adds a single-step mode for board debug and a retired-instruction counter.

---
 rtl/cu_bj_pkg.sv | 54 +++++
 rtl/cu_bj_step_edge.sv | 47 ++++
 rtl/cu_bj.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cu_bj_pkg.sv
// ============================================================================
// Module  : cu_bj_pkg
// Purpose : Shared definitions for the cu_bj multi-cycle control unit:
//           FSM state codes, ALU operation constants, and the encodings of
//           the next-PC and write-back mux selects.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cu_bj_pkg;

  // State codes double as the externally visible ST value.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_EX   = 4'd3,
    S_WB   = 4'd4,
    S_LUI  = 4'd5,
    S_MA   = 4'd6,
    S_MR   = 4'd7,
    S_LD   = 4'd8,
    S_MW   = 4'd9,
    S_BR   = 4'd10,
    S_BT   = 4'd11,
    S_JAL  = 4'd12,
    S_JALR = 4'd13,
    S_JR   = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Next-PC source select
  localparam logic [1:0] PC_INC = 2'b00;  // PC + 1 word
  localparam logic [1:0] PC_REL = 2'b01;  // PC0 + imm
  localparam logic [1:0] PC_ABS = 2'b10;  // F with bit0 cleared

  // Register write-back source select
  localparam logic [1:0] WB_F    = 2'b00;
  localparam logic [1:0] WB_IMM  = 2'b01;
  localparam logic [1:0] WB_MDR  = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;

  // States whose exit into S_IDLE retires an instruction.
  function automatic logic retires(input state_t s);
    return (s == S_WB)  || (s == S_LUI) || (s == S_LD) || (s == S_MW) ||
           (s == S_BT)  || (s == S_JAL) || (s == S_JR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cu_bj_step_edge.sv
// ============================================================================
// Module  : step_edge
// Purpose : Debug single-step front end. Synchronises the asynchronous step
//           level, detects its rising edge and holds at most one pending
//           request until the FSM consumes it in S_IDLE.
// Ports   : clk     - system clock
//           rst     - asynchronous active-low reset
//           step    - raw step level from the board
//           consume - high while the FSM sits in S_IDLE
//           go      - a fresh or pending step request is available
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module step_edge (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic consume,
  output logic go
);

  logic sync1, sync2, prev, pending;
  logic rise;

  assign rise = sync2 & ~prev;
  // A rise seen in S_IDLE is used directly; one seen mid-instruction is
  // parked in pending and picked up at the next S_IDLE.
  assign go   = pending | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1   <= step;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= (pending | rise) & ~consume;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cu_bj.sv
// ============================================================================
// Module  : cu_bj
// Purpose : Moore-FSM control unit for the multi-cycle RV32 subset CPU with
//           BEQ/BNE/JAL/JALR, single-step debug mode and a retired
//           instruction counter.
// Ports   : clk, rst (async active-low)
//           IS_R..IS_JALR  - decoder class flags
//           ALU_OP, FR     - decoder ALU op, ALU flag register
//           step_mode/step - single-step control
//           PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write - enables
//           PC_s, rs2_imm_s, w_data_s, OP - datapath selects / ALU op
//           ST  - current state code, ILL - illegal-class pulse
//           instr_cnt - retired instruction count
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_bj
  import cu_bj_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ZF_BIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IS_R,
  input  logic             IS_IMM,
  input  logic             IS_LUI,
  input  logic             IS_LW,
  input  logic             IS_SW,
  input  logic             IS_BEQ,
  input  logic             IS_BNE,
  input  logic             IS_JAL,
  input  logic             IS_JALR,
  input  logic [3:0]       ALU_OP,
  input  logic [3:0]       FR,
  input  logic             step_mode,
  input  logic             step,
  output logic             PC_Write,
  output logic             PC0_Write,
  output logic             IR_Write,
  output logic             Reg_Write,
  output logic             Mem_Write,
  output logic [1:0]       PC_s,
  output logic             rs2_imm_s,
  output logic [1:0]       w_data_s,
  output logic [3:0]       OP,
  output logic [3:0]       ST,
  output logic             ILL,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state, state_nx;
  logic   step_go;
  logic   zf;
  logic   unused_fr;

  assign zf        = FR[ZF_BIT];
  assign unused_fr = ^FR;
  assign ST        = state;

  step_edge u_step_edge (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .consume (state == S_IDLE),
    .go      (step_go)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                instr_cnt <= '0;
    else if (retires(state)) instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_nx  = S_IDLE;
    PC_Write  = 1'b0;
    PC0_Write = 1'b0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    Mem_Write = 1'b0;
    PC_s      = PC_INC;
    rs2_imm_s = 1'b0;
    w_data_s  = WB_F;
    OP        = ALU_ADD;
    ILL       = 1'b0;
    case (state)
      S_IDLE: state_nx = (!step_mode || step_go) ? S_IF : S_IDLE;
      S_IF: begin
        IR_Write  = 1'b1;
        PC_Write  = 1'b1;
        PC0_Write = 1'b1;
        PC_s      = PC_INC;
        state_nx  = S_ID;
      end
      S_ID: begin
        if      (IS_R || IS_IMM)   state_nx = S_EX;
        else if (IS_LUI)           state_nx = S_LUI;
        else if (IS_LW || IS_SW)   state_nx = S_MA;
        else if (IS_BEQ || IS_BNE) state_nx = S_BR;
        else if (IS_JAL)           state_nx = S_JAL;
        else if (IS_JALR)          state_nx = S_JALR;
        else begin
          ILL      = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_EX: begin
        OP        = ALU_OP;
        rs2_imm_s = IS_IMM;
        state_nx  = S_WB;
      end
      S_WB: begin
        Reg_Write = 1'b1;
        w_data_s  = WB_F;
      end
      S_LUI: begin
        Reg_Write = 1'b1;
        w_data_s  = WB_IMM;
      end
      S_MA: begin
        OP        = ALU_ADD;
        rs2_imm_s = 1'b1;
        state_nx  = IS_LW ? S_MR : S_MW;
      end
      S_MR: state_nx = S_LD;  // MDR captures RAM data on this cycle
      S_LD: begin
        Reg_Write = 1'b1;
        w_data_s  = WB_MDR;
      end
      S_MW: Mem_Write = 1'b1;
      S_BR: begin
        OP        = ALU_SUB;
        rs2_imm_s = 1'b0;
        state_nx  = S_BT;
      end
      S_BT: begin
        PC_s     = PC_REL;
        PC_Write = (IS_BEQ & zf) | (IS_BNE & ~zf);
      end
      S_JAL: begin
        Reg_Write = 1'b1;
        w_data_s  = WB_LINK;
        PC_Write  = 1'b1;
        PC_s      = PC_REL;
      end
      S_JALR: begin
        OP        = ALU_ADD;
        rs2_imm_s = 1'b1;
        state_nx  = S_JR;
      end
      // Target already latched in F, so linking into rd == rs1 is safe.
      S_JR: begin
        Reg_Write = 1'b1;
        w_data_s  = WB_LINK;
        PC_Write  = 1'b1;
        PC_s      = PC_ABS;
      end
      default: state_nx = S_IDLE;  // unused code 15 recovers
    endcase
  end

endmodule

`default_nettype wire
